// File: rtl/dmux_nway_stream.sv
// dmux_nway_stream: registered N-way valid/ready stream demultiplexer.
// Each output channel owns a one-entry register, so one stalled consumer
// never blocks traffic to the others. Words with an out-of-range select are
// accepted, discarded and counted in a saturating 8-bit counter.
// Optional feature: define DMUX_NWAY_BROADCAST_EN to add the in_bcast input,
// which loads one word into every channel at once.
module dmux_nway_stream #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
`ifdef DMUX_NWAY_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [7:0]                drop_count
);

  localparam logic [7:0] DROP_MAX = 8'hFF;

  logic                             bcast;
  logic [CHANNELS-1:0]              can;
  logic [CHANNELS-1:0]              load;
  logic                             in_range;
  logic                             sel_can;
  logic                             accept;
  logic                             drop;
  logic [CHANNELS-1:0][WIDTH-1:0]   data_q;

`ifdef DMUX_NWAY_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Slice k of the packed register array sits at [k*WIDTH +: WIDTH].
  assign out_data = data_q;

  // Readiness, acceptance and per-channel load decode.
  always_comb begin
    can      = ~out_valid | out_ready;
    in_range = 32'(in_sel) < CHANNELS;
    // Out-of-range selects are always ready: the word is simply dropped.
    sel_can  = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_sel == SEL_W'(k)) sel_can = can[k];
    end
    in_ready = bcast ? (&can) : sel_can;
    accept   = in_valid & in_ready;
    drop     = accept & ~bcast & ~in_range;
    load     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = accept & (bcast | (in_sel == SEL_W'(k)));
    end
  end

  // Channel registers: a fill wins over a drain on the same edge, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      data_q    <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        out_valid[k] <= load[k] | (out_valid[k] & ~out_ready[k]);
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != DROP_MAX)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmux_nway_stream.sv
// Bench for dmux_nway_stream: a 4-channel and a 3-channel instance checked
// against per-channel word queues and a drop counter kept in the bench.
module tb_dmux_nway_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic [1:0]  isel [2];
  logic [15:0] idat [2];
  logic [3:0]  ordy [2];
`ifdef DMUX_NWAY_BROADCAST_EN
  logic        bc   [2];
`endif

  logic        rdy4, rdy3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [63:0] od4;
  logic [47:0] od3;
  logic [7:0]  dc4, dc3;

  logic        obs_rdy [2];
  logic [3:0]  obs_v   [2];
  logic [15:0] obs_d   [2][4];
  logic [7:0]  obs_dc  [2];

  // Reference: each channel is a queue of words it owes its consumer.
  logic [15:0] mq [2][4][$];
  int          mdrop [2];
  int          nch   [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmux_nway_stream #(.WIDTH(16), .CHANNELS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy4),
    .in_data(idat[0]), .in_sel(isel[0]),
`ifdef DMUX_NWAY_BROADCAST_EN
    .in_bcast(bc[0]),
`endif
    .out_valid(ov4), .out_ready(ordy[0]), .out_data(od4), .drop_count(dc4)
  );

  dmux_nway_stream #(.WIDTH(16), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy3),
    .in_data(idat[1]), .in_sel(isel[1]),
`ifdef DMUX_NWAY_BROADCAST_EN
    .in_bcast(bc[1]),
`endif
    .out_valid(ov3), .out_ready(ordy[1][2:0]), .out_data(od3), .drop_count(dc3)
  );

  // Gather both instances into uniformly indexed views.
  always_comb begin
    obs_rdy[0] = rdy4;
    obs_rdy[1] = rdy3;
    obs_v[0]   = ov4;
    obs_v[1]   = {1'b0, ov3};
    obs_dc[0]  = dc4;
    obs_dc[1]  = dc3;
    for (int k = 0; k < 4; k++) obs_d[0][k] = od4[k*16 +: 16];
    for (int k = 0; k < 3; k++) obs_d[1][k] = od3[k*16 +: 16];
    obs_d[1][3] = '0;
  end

  // A destination can take a word if it owes nothing or its consumer is ready.
  function automatic bit exp_ready(int d);
    bit r;
    r = 1'b1;
`ifdef DMUX_NWAY_BROADCAST_EN
    if (bc[d]) begin
      for (int k = 0; k < nch[d]; k++)
        if (mq[d][k].size() != 0 && !ordy[d][k]) r = 1'b0;
      return r;
    end
`endif
    if (int'(isel[d]) < nch[d])
      r = (mq[d][isel[d]].size() == 0) || ordy[d][isel[d]];
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mdrop[d] = 0;
      for (int k = 0; k < 4; k++) mq[d][k].delete();
    end
  endtask

  // One clock: decide transfers from current inputs, then update the queues.
  task automatic step();
    bit          acc [2];
    bit          drn [2][4];
    bit          bca [2];
    logic [1:0]  s   [2];
    logic [15:0] w   [2];
    for (int d = 0; d < 2; d++) begin
      acc[d] = iv[d] && exp_ready(d);
      s[d]   = isel[d];
      w[d]   = idat[d];
`ifdef DMUX_NWAY_BROADCAST_EN
      bca[d] = bc[d];
`else
      bca[d] = 1'b0;
`endif
      for (int k = 0; k < 4; k++)
        drn[d][k] = (k < nch[d]) && (mq[d][k].size() != 0) && ordy[d][k];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nch[d]; k++)
        if (drn[d][k]) void'(mq[d][k].pop_front());
      if (acc[d]) begin
        if (bca[d]) begin
          for (int k = 0; k < nch[d]; k++) mq[d][k].push_back(w[d]);
        end else if (int'(s[d]) < nch[d]) begin
          mq[d][s[d]].push_back(w[d]);
        end else if (mdrop[d] < 255) begin
          mdrop[d]++;
        end
      end
    end
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; isel[d] = '0; idat[d] = '0; ordy[d] = 4'hF;
`ifdef DMUX_NWAY_BROADCAST_EN
      bc[d] = 1'b0;
`endif
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    isel[0] = 2'd2;
    #3;
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL reset_valid4: got %h want 0", ov4); end
    checks++; if (od4 !== 64'h0) begin errors++; $display("FAIL reset_data4: got %h want 0", od4); end
    checks++; if (dc4 !== 8'h0) begin errors++; $display("FAIL reset_drop4: got %0d want 0", dc4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready_sel2: got %b want 1", rdy4); end
    checks++; if (ov3 !== 3'h0) begin errors++; $display("FAIL reset_valid3: got %h want 0", ov3); end
    checks++; if (od3 !== 48'h0) begin errors++; $display("FAIL reset_data3: got %h want 0", od3); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step();
  endtask

  task automatic test_round_robin();
    idle();
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; isel[0] = 2'(i); idat[0] = 16'hA001 + 16'(i);
      #1;
      checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL rr_ready word %0d: got %b want 1", i, rdy4); end
      step();
      checks++; if (ov4 !== 4'(1 << i)) begin errors++; $display("FAIL rr_valid word %0d: got %b want %b", i, ov4, 4'(1 << i)); end
      checks++; if (obs_d[0][i] !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL rr_data word %0d: got %h want %h", i, obs_d[0][i], 16'hA001 + 16'(i)); end
    end
    iv[0] = 1'b0;
    step();
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL rr_drained: got %b want 0000", ov4); end
  endtask

  task automatic test_stall();
    idle();
    ordy[0] = 4'b1101;
    iv[0] = 1'b1; isel[0] = 2'd1; idat[0] = 16'h1111;
    step();
    checks++; if (ov4[1] !== 1'b1 || obs_d[0][1] !== 16'h1111) begin errors++; $display("FAIL stall_first: got v=%b d=%h want v=1 d=1111", ov4[1], obs_d[0][1]); end
    idat[0] = 16'h2222;
    #1;
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", rdy4); end
    step();
    checks++; if (ov4[1] !== 1'b1 || obs_d[0][1] !== 16'h1111) begin errors++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=1111", ov4[1], obs_d[0][1]); end
    isel[0] = 2'd3; idat[0] = 16'h3333;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL stall_other_ready: got %b want 1", rdy4); end
    step();
    checks++; if (ov4 !== 4'b1010 || obs_d[0][3] !== 16'h3333) begin errors++; $display("FAIL stall_other_data: got v=%b d=%h want v=1010 d=3333", ov4, obs_d[0][3]); end
    isel[0] = 2'd1; idat[0] = 16'h2222;
    #1;
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL stall_ready_again: got %b want 0", rdy4); end
    ordy[0] = 4'hF;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", rdy4); end
    step();
    checks++; if (ov4 !== 4'b0010 || obs_d[0][1] !== 16'h2222) begin errors++; $display("FAIL stall_no_bubble: got v=%b d=%h want v=0010 d=2222", ov4, obs_d[0][1]); end
    iv[0] = 1'b0;
    step();
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL stall_drained: got %b want 0000", ov4); end
  endtask

  task automatic test_drop_saturate();
    idle();
    iv[1] = 1'b1; isel[1] = 2'd3;
    for (int i = 0; i < 300; i++) begin
      idat[1] = 16'($urandom);
      #1;
      checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL drop_ready word %0d: got %b want 1", i, rdy3); end
      step();
      checks++; if (ov3 !== 3'b000 || dc3 !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        errors++; $display("FAIL drop_count word %0d: got v=%b cnt=%0d want v=000 cnt=%0d", i, ov3, dc3, (i + 1 > 255) ? 255 : i + 1);
      end
    end
    iv[1] = 1'b0;
    step();
    checks++; if (dc3 !== 8'd255) begin errors++; $display("FAIL drop_final: got %0d want 255", dc3); end
  endtask

  task automatic test_async_reset();
    idle();
    ordy[0] = 4'b1110;
    iv[0] = 1'b1; isel[0] = 2'd0; idat[0] = 16'hBEEF;
    step();
    iv[0] = 1'b0;
    checks++; if (ov4[0] !== 1'b1) begin errors++; $display("FAIL areset_loaded: got %b want 1", ov4[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov4 !== 4'h0 || od4 !== 64'h0) begin errors++; $display("FAIL areset_clear: got v=%b d=%h want 0", ov4, od4); end
    checks++; if (dc3 !== 8'h0) begin errors++; $display("FAIL areset_drop: got %0d want 0", dc3); end
    rst_n = 1'b1;
    model_clear();
    ordy[0] = 4'hF;
    repeat (2) step();
    checks++; if (ov4 !== 4'h0) begin errors++; $display("FAIL areset_lost: got %b want 0000", ov4); end
  endtask

`ifdef DMUX_NWAY_BROADCAST_EN
  task automatic test_broadcast();
    idle();
    ordy[0] = 4'b1011;
    iv[0] = 1'b1; isel[0] = 2'd2; idat[0] = 16'h7777;
    step();
    bc[0] = 1'b1; idat[0] = 16'h5A5A; isel[0] = 2'd0;
    #1;
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL bcast_blocked: got %b want 0", rdy4); end
    step();
    checks++; if (ov4 !== 4'b0100 || obs_d[0][2] !== 16'h7777) begin errors++; $display("FAIL bcast_hold: got v=%b d=%h want v=0100 d=7777", ov4, obs_d[0][2]); end
    ordy[0] = 4'hF;
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL bcast_ready: got %b want 1", rdy4); end
    step();
    checks++; if (ov4 !== 4'hF) begin errors++; $display("FAIL bcast_valid: got %b want 1111", ov4); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (obs_d[0][k] !== 16'h5A5A) begin errors++; $display("FAIL bcast_data ch%0d: got %h want 5a5a", k, obs_d[0][k]); end
    end
    checks++; if (dc4 !== 8'h0) begin errors++; $display("FAIL bcast_drop: got %0d want 0", dc4); end
    iv[0] = 1'b0; bc[0] = 1'b0;
    step();
  endtask
`endif

  task automatic test_random();
    idle();
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = 1'($urandom_range(0, 3) != 0);
        isel[d] = 2'($urandom);
        idat[d] = 16'($urandom);
        ordy[d] = 4'($urandom);
`ifdef DMUX_NWAY_BROADCAST_EN
        bc[d]   = 1'($urandom_range(0, 7) == 0);
`endif
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++; if (obs_rdy[d] !== exp_ready(d)) begin errors++; $display("FAIL rand_ready dut%0d cyc %0d: got %b want %b", d, c, obs_rdy[d], exp_ready(d)); end
        checks++; if (obs_dc[d] !== 8'(mdrop[d])) begin errors++; $display("FAIL rand_drop dut%0d cyc %0d: got %0d want %0d", d, c, obs_dc[d], mdrop[d]); end
        for (int k = 0; k < nch[d]; k++) begin
          checks++; if (obs_v[d][k] !== (mq[d][k].size() != 0)) begin errors++; $display("FAIL rand_valid dut%0d ch%0d cyc %0d: got %b want %b", d, k, c, obs_v[d][k], mq[d][k].size() != 0); end
          if (mq[d][k].size() != 0) begin
            checks++; if (obs_d[d][k] !== mq[d][k][0]) begin errors++; $display("FAIL rand_data dut%0d ch%0d cyc %0d: got %h want %h", d, k, c, obs_d[d][k], mq[d][k][0]); end
          end
        end
      end
      step();
    end
  endtask

  initial begin
    nch[0] = 4;
    nch[1] = 3;
    model_clear();
    test_reset();
    test_round_robin();
    test_stall();
    test_drop_saturate();
    test_async_reset();
`ifdef DMUX_NWAY_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
